// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline types for the hazard controller
package pipeline_pkg;
    localparam int REG_W_DEF = 4;
    typedef enum logic {RUN, LU_STALL} hz_state_t;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10} fwd_sel_t;
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline-stage view seen by the hazard controller
interface hazard_unit_if #(parameter int REG_W = 4, parameter int CNT_W = 16) ();
    logic [REG_W-1:0] id_ra, id_rb, ex_ra, ex_rb, ex_rd, mem_rd, wb_rd;
    logic id_ra_used, id_rb_used, ex_wbs, ex_mm, mem_wbs, wb_wbs, branch_taken;
    logic stall_fd, flush_fd, flush_de;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cycles, flush_cycles;
    modport master (
        output id_ra, id_rb, ex_ra, ex_rb, ex_rd, mem_rd, wb_rd,
        output id_ra_used, id_rb_used, ex_wbs, ex_mm, mem_wbs, wb_wbs, branch_taken,
        input stall_fd, flush_fd, flush_de, fwd_a, fwd_b, stall_cycles, flush_cycles
    );
    modport slave (
        input id_ra, id_rb, ex_ra, ex_rb, ex_rd, mem_rd, wb_rd,
        input id_ra_used, id_rb_used, ex_wbs, ex_mm, mem_wbs, wb_wbs, branch_taken,
        output stall_fd, flush_fd, flush_de, fwd_a, fwd_b, stall_cycles, flush_cycles
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(parameter int CNT_W = 16) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    // count up on inc until every bit is set
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, branch flush and operand forwarding control
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int REG_W      = REG_W_DEF,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input logic clk,
    input logic rst,
    hazard_unit_if.slave bus
);
    hz_state_t state;
    logic [2:0] cnt;
    logic lu, stall_fd, flush_fd, flush_de;

    function automatic fwd_sel_t fwd(input logic [REG_W-1:0] src);
        return (bus.mem_wbs && bus.mem_rd == src) ? FWD_MEM :
               (bus.wb_wbs && bus.wb_rd == src) ? FWD_WB : FWD_RF;
    endfunction

    assign lu = bus.ex_mm && bus.ex_wbs &&
                ((bus.id_ra_used && bus.id_ra == bus.ex_rd) || (bus.id_rb_used && bus.id_rb == bus.ex_rd));

    // reset forces a bubble, a taken branch flushes, otherwise stall while a load-use is pending
    always_comb begin
        stall_fd = !rst && !bus.branch_taken && (state == LU_STALL || lu);
        flush_fd = rst || bus.branch_taken;
        flush_de = rst || bus.branch_taken || stall_fd;
    end

    assign bus.stall_fd = stall_fd;
    assign bus.flush_fd = flush_fd;
    assign bus.flush_de = flush_de;
    assign bus.fwd_a = rst ? FWD_RF : fwd(bus.ex_ra);
    assign bus.fwd_b = rst ? FWD_RF : fwd(bus.ex_rb);

    // the detection cycle is the first bubble; LU_STALL supplies the remaining LOAD_STALL-1
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else if (bus.branch_taken) begin
            state <= RUN;
            cnt   <= '0;
        end else if (state == RUN) begin
            state <= (lu && LOAD_STALL > 1) ? LU_STALL : RUN;
            cnt   <= (lu && LOAD_STALL > 1) ? 3'(LOAD_STALL - 1) : 3'd0;
        end else begin
            state <= (cnt == 3'd1) ? RUN : LU_STALL;
            cnt   <= cnt - 3'd1;
        end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(stall_fd), .count(bus.stall_cycles));
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(flush_fd), .count(bus.flush_cycles));
endmodule
